// File: rtl/counter_pkg.sv
// Shared constants and the count type for the modulo-9 counter exercises.
`timescale 1ns/1ps
package counter_pkg;

  localparam int unsigned CNT9_W   = 4;
  localparam int unsigned CNT9_MOD = 9;
  localparam int unsigned CNT9_MAX = CNT9_MOD - 1;

  typedef logic [CNT9_W-1:0] cnt9_t;

endpackage

// File: rtl/modn_counter_core.sv
// Generic modulo-N up-counter core: state register, wrap logic and
// recovery from out-of-range values. Optional checks under ASSERT_ON.
`timescale 1ns/1ps
module modn_counter_core
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT9_W,
  parameter int unsigned MODULUS = CNT9_MOD
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [WIDTH-1:0] q_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One bit wider so MODULUS == 2**WIDTH does not alias to zero.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             illegal_c;

  assign illegal_c = ({1'b0, q_q} >= MOD_EXT);

  // Next count: wrap at MAX, reload 0 from any out-of-range value.
  always_comb begin
    q_d = q_q + WIDTH'(1);
    if (illegal_c || (q_q == MAX_VAL)) begin
      q_d = '0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

`ifdef ASSERT_ON
  // Count stays in range on the edge following a reset.
  a_range_after_rst : assert property (@(posedge clk_i)
    $past(rst_i) |-> ({1'b0, q_q} < MOD_EXT));

  // Next-state matches the wrap rule whenever the state is legal.
  a_next_state : assert property (@(posedge clk_i)
    (!rst_i && !illegal_c) |-> (q_d == ((q_q == MAX_VAL) ? '0 : q_q + WIDTH'(1))));
`endif

endmodule

// File: rtl/counter9_c1.sv
// Modulo-9 free-running counter wrapper around modn_counter_core.
// Optional terminal-count output tc when COUNTER9_C1_TC_EN is defined.
`timescale 1ns/1ps
module counter9_c1
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT9_W,
  parameter int unsigned MODULUS = CNT9_MOD
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q
`ifdef COUNTER9_C1_TC_EN
  ,
  output logic             tc
`endif
);

  // Reject count lengths that cannot be represented or are degenerate.
  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_param_err
    $error("counter9_c1: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  // rst_n is active-high here; the name is historical.
  modn_counter_core #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_core (
    .clk_i (clk),
    .rst_i (rst_n),
    .q_o   (q)
  );

`ifdef COUNTER9_C1_TC_EN
  // q reaches MAX exactly one edge after it holds MAX-1, so registering
  // that condition aligns tc with the cycle where q == MAX.
  localparam logic [WIDTH-1:0] PRE_MAX = WIDTH'(MODULUS - 2);

  logic tc_q;
  logic tc_d;

  // Terminal-count lookahead.
  always_comb begin
    tc_d = 1'b0;
    if (q == PRE_MAX) begin
      tc_d = 1'b1;
    end
  end

  // Terminal-count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign tc = tc_q;
`endif

endmodule

// File: tb/tb_counter9_c1.sv
// Directed bench for counter9_c1 with an expected-value queue.
`timescale 1ns/1ps
module tb_counter9_c1;
  import counter_pkg::*;

  logic  clk;
  logic  rst_n;
  cnt9_t q;
`ifdef COUNTER9_C1_TC_EN
  logic  tc;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  cnt9_t exp_q[$];
  cnt9_t model_q;

  counter9_c1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
`ifdef COUNTER9_C1_TC_EN
    ,
    .tc    (tc)
`endif
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  function automatic cnt9_t ref_next(input cnt9_t cur);
    return (cur == cnt9_t'(8)) ? cnt9_t'(0) : cnt9_t'(cur + 4'd1);
  endfunction

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    assert (act === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Drive reset level, push the expected q, clock once, pop and compare.
  task automatic step(input logic rst, input cnt9_t exp, input string tag);
    cnt9_t e;
    rst_n = rst;
    exp_q.push_back(exp);
    @(posedge clk);
    #0.5;
    e = exp_q.pop_front();
    check(tag, 8'(q), 8'(e));
`ifdef COUNTER9_C1_TC_EN
    check({tag, "_tc"}, 8'(tc), 8'(e == cnt9_t'(8)));
`endif
    model_q = e;
  endtask

  initial begin
    cnt9_t t2 [12];
    cnt9_t t4 [5];
    t2 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd1, 4'd2, 4'd3};
    t4 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    rst_n = 1'b1;

    // T1: reset holds q at 0.
    for (int i = 0; i < 3; i++) step(1'b1, 4'd0, "t1_reset");

    // T2: count sequence after release.
    for (int i = 0; i < 12; i++) step(1'b0, t2[i], "t2_seq");

    // T3: run up to 8, then wrap to 0.
    while (model_q != cnt9_t'(8)) step(1'b0, ref_next(model_q), "t3_run");
    step(1'b0, 4'd0, "t3_wrap");

    // T4: reset in the middle of a count.
    for (int i = 0; i < 5; i++) step(1'b0, t4[i], "t4_up");
    step(1'b1, 4'd0, "t4_midrst");
    step(1'b0, 4'd1, "t4_resume1");
    step(1'b0, 4'd2, "t4_resume2");

    // T5: illegal state is recovered on the next edge.
    force dut.u_core.q_q = 4'd13;
    #0.2;
    check("t5_forced", 8'(q), 8'd13);
    release dut.u_core.q_q;
    step(1'b0, 4'd0, "t5_recover");
    step(1'b0, 4'd1, "t5_after1");
    step(1'b0, 4'd2, "t5_after2");

    // T6: 15 edges after reset release end at 6 with no X.
    step(1'b1, 4'd0, "t6_reset");
    for (int i = 0; i < 15; i++) begin
      step(1'b0, ref_next(model_q), "t6_run");
      check("t6_noX", 8'($isunknown(q)), 8'd0);
    end
    check("t6_final", 8'(q), 8'd6);

    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
